// File: rtl/ddr_packet_reader_256.sv
// Avalon-MM burst reader: fetches a length-prefixed packet image from DDR and streams 32-bit words.
// Optional: define DDR_PACKET_READER_BSWAP_EN to emit each dword byte-reversed (network order).
module ddr_packet_reader_256 #(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned MAX_BURST  = 64,
    parameter int unsigned FIFO_DEPTH = 128,
    parameter int unsigned MAX_LEN    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] amm_addr_o,
    output logic              amm_read_o,
    output logic [6:0]        amm_burstcount_o,
    output logic [31:0]       amm_byteenable_o,
    input  logic              amm_ready_i,
    input  logic [255:0]      amm_readdata_i,
    input  logic              amm_readdatavalid_i,
    output logic [31:0]       tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              tx_last_o,
    output logic [1:0]        tx_empty_o
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        StIdle, StHdrReq, StHdrWait, StCheck, StDataReq, StDrain, StDone, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic [15:0]       len_q, len_d, dwords_q, dwords_d, remaining_q, remaining_d;
    logic [15:0]       emit_q, emit_d;
    logic [CW-1:0]     outst_q, outst_d, cnt_q, cnt_d;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [2:0]        dw_idx_q, dw_idx_d;
    logic [255:0]      mem_q [FIFO_DEPTH];

    logic [6:0]   burst;
    logic         data_phase, credit_ok, accept, push, pop, tx_hs, last_dw;
    logic [255:0] head;
    logic [31:0]  dword_raw, dword;
    logic [16:0]  len_ext;

    assign data_phase = (state_q == StDataReq) || (state_q == StDrain);
    assign burst      = (32'(remaining_q) > MAX_BURST) ? 7'(MAX_BURST) : remaining_q[6:0];
    // Reserving space for in-flight beats means an accepted burst always fits in the FIFO.
    assign credit_ok  = (32'(cnt_q) + 32'(outst_q) + 32'(burst)) <= FIFO_DEPTH;
    assign accept     = (state_q == StDataReq) && amm_read_o && amm_ready_i;
    // Beats with nothing outstanding belong to a burst abandoned by reset and are dropped.
    assign push       = amm_readdatavalid_i && data_phase && (outst_q != '0);
    assign len_ext    = {1'b0, len_q};

    assign head       = mem_q[rptr_q];
    assign dword_raw  = head[{dw_idx_q, 5'd0} +: 32];
`ifdef DDR_PACKET_READER_BSWAP_EN
    assign dword = {dword_raw[7:0], dword_raw[15:8], dword_raw[23:16], dword_raw[31:24]};
`else
    assign dword = dword_raw;
`endif

    assign tx_valid_o = data_phase && (cnt_q != '0);
    assign last_dw    = (emit_q == dwords_q - 16'd1);
    assign tx_hs      = tx_valid_o && tx_ready_i;
    assign pop        = tx_hs && (last_dw || (dw_idx_q == 3'd7));
    assign tx_data_o  = tx_valid_o ? dword : 32'd0;
    assign tx_last_o  = tx_valid_o && last_dw;
    assign tx_empty_o = tx_last_o ? (2'd0 - len_q[1:0]) : 2'd0;

    assign busy_o           = (state_q != StIdle);
    assign done_o           = (state_q == StDone);
    assign error_o          = (state_q == StErr);
    assign amm_byteenable_o = '1;

    assign outst_d  = outst_q + (accept ? CW'(burst) : CW'(0)) - CW'(push);
    assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
    assign emit_d   = (state_q == StCheck) ? 16'd0 : (tx_hs ? emit_q + 16'd1 : emit_q);
    assign dw_idx_d = ((state_q == StCheck) || pop) ? 3'd0 :
                      (tx_hs ? dw_idx_q + 3'd1 : dw_idx_q);

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        addr_d           = addr_q;
        len_d            = len_q;
        dwords_d         = dwords_q;
        remaining_d      = remaining_q;
        amm_read_o       = 1'b0;
        amm_addr_o       = '0;
        amm_burstcount_o = 7'd0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    state_d = StHdrReq;
                end
            end
            StHdrReq: begin
                amm_read_o       = 1'b1;
                amm_addr_o       = base_q;
                amm_burstcount_o = 7'd1;
                if (amm_ready_i) state_d = StHdrWait;
            end
            StHdrWait: begin
                if (amm_readdatavalid_i) begin
                    len_d   = amm_readdata_i[15:0];
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (len_q == 16'd0 || 32'(len_q) > MAX_LEN) begin
                    state_d = StErr;
                end else begin
                    remaining_d = 16'((len_ext + 17'd31) >> 5);
                    dwords_d    = 16'((len_ext + 17'd3) >> 2);
                    addr_d      = base_q + ADDR_W'(1);
                    state_d     = StDataReq;
                end
            end
            StDataReq: begin
                if (credit_ok) begin
                    amm_read_o       = 1'b1;
                    amm_addr_o       = addr_q;
                    amm_burstcount_o = burst;
                    if (amm_ready_i) begin
                        addr_d      = addr_q + ADDR_W'(burst);
                        remaining_d = remaining_q - 16'(burst);
                        if (remaining_q == 16'(burst)) state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (tx_hs && last_dw && outst_q == '0) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            dwords_q    <= '0;
            remaining_q <= '0;
            emit_q      <= '0;
            outst_q     <= '0;
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            dw_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            dwords_q    <= dwords_d;
            remaining_q <= remaining_d;
            emit_q      <= emit_d;
            outst_q     <= outst_d;
            cnt_q       <= cnt_d;
            dw_idx_q    <= dw_idx_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= amm_readdata_i;
    end

endmodule

// File: tb/tb_ddr_packet_reader_256.sv
// Directed bench for ddr_packet_reader_256 with a small Avalon-MM slave model and tx sink.
module tb_ddr_packet_reader_256;
    localparam int unsigned ADDR_W = 25;

    logic              clk = 1'b0;
    logic              reset, start, busy, done, err;
    logic [ADDR_W-1:0] base_addr, amm_addr;
    logic              amm_read, amm_ready, amm_rvalid;
    logic [6:0]        amm_bc;
    logic [31:0]       amm_be, tx_data;
    logic [255:0]      amm_rdata;
    logic              tx_valid, tx_ready, tx_last;
    logic [1:0]        tx_empty;

    ddr_packet_reader_256 dut (
        .clk(clk), .reset(reset), .start_i(start), .base_addr_i(base_addr),
        .busy_o(busy), .done_o(done), .error_o(err),
        .amm_addr_o(amm_addr), .amm_read_o(amm_read), .amm_burstcount_o(amm_bc),
        .amm_byteenable_o(amm_be), .amm_ready_i(amm_ready), .amm_readdata_i(amm_rdata),
        .amm_readdatavalid_i(amm_rvalid),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .tx_last_o(tx_last), .tx_empty_o(tx_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic              hdr;
    } beat_t;

    logic [255:0]      ddr [512];
    beat_t             pend[$];
    logic [ADDR_W-1:0] cmd_a[$];
    logic [6:0]        cmd_bc[$];
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] cur_base, hold_a;
    logic [6:0]        hold_bc;
    logic [31:0]       first_dw;
    logic [1:0]        exp_empty, last_empty;
    bit  rdy_rand, cmd_rand, rv_en, rv_rand, rv_hdr, hold_v, got_done, got_err;
    int  n_cmp, n_err, exp_total, rx_idx, tx_cnt, vld_cnt, occ, occ_max;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bsw(input logic [31:0] d);
`ifdef DDR_PACKET_READER_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    function automatic logic [31:0] cmd_word(input int i);
        if (i < cmd_a.size()) return {cmd_bc[i], cmd_a[i]};
        return '1;
    endfunction

    // Slave and sink drivers, updated just after each rising edge.
    initial begin
        beat_t b;
        amm_ready = 1'b0; amm_rvalid = 1'b0; amm_rdata = '0; tx_ready = 1'b1; rv_hdr = 1'b0;
        forever begin
            @(posedge clk); #1;
            amm_ready  = cmd_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            tx_ready   = rdy_rand ? ($urandom_range(0, 9) >= 3) : 1'b1;
            amm_rvalid = 1'b0;
            if (pend.size() > 0 && (rv_en || pend[0].hdr) &&
                (!rv_rand || $urandom_range(0, 4) != 0)) begin
                b          = pend.pop_front();
                amm_rvalid = 1'b1;
                amm_rdata  = ddr[b.a[8:0]];
                rv_hdr     = b.hdr;
            end
        end
    end

    // Monitor on the falling edge: commands, beats, FIFO occupancy and the tx stream.
    initial begin
        beat_t b;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (amm_read) begin
                    if (hold_v) check("cmd_stable", {amm_bc, amm_addr}, {hold_bc, hold_a});
                    if (amm_ready) begin
                        cmd_a.push_back(amm_addr);
                        cmd_bc.push_back(amm_bc);
                        for (int i = 0; i < int'(amm_bc); i++) begin
                            b.a   = amm_addr + ADDR_W'(i);
                            b.hdr = (amm_addr == cur_base) && (amm_bc == 7'd1);
                            pend.push_back(b);
                        end
                        hold_v = 1'b0;
                    end else begin
                        hold_v = 1'b1; hold_a = amm_addr; hold_bc = amm_bc;
                    end
                end else if (hold_v) begin
                    check("cmd_dropped", amm_read, 1);
                    hold_v = 1'b0;
                end
                if (amm_rvalid && !rv_hdr && busy) occ++;
                if (occ > occ_max) occ_max = occ;
                if (tx_valid) vld_cnt++;
                if (tx_valid && tx_ready) begin
                    tx_cnt++;
                    if (exp_q.size() == 0) begin
                        check("tx_extra", tx_cnt, exp_total);
                    end else begin
                        e = exp_q.pop_front();
                        if (rx_idx == 0) first_dw = tx_data;
                        if (tx_last) last_empty = tx_empty;
                        check("tx_data", tx_data, e);
                        check("tx_last", tx_last, rx_idx == exp_total - 1);
                        check("tx_empty", tx_empty, (rx_idx == exp_total - 1) ? exp_empty : 2'd0);
                        if (rx_idx % 8 == 7 || rx_idx == exp_total - 1) occ--;
                        rx_idx++;
                    end
                end
                if (done) got_done = 1'b1;
                if (err)  got_err  = 1'b1;
            end
        end
    end

    task automatic setup_pkt(input int base, input int len, input bit exp_err);
        int dw;
        cur_base = ADDR_W'(base);
        cmd_a.delete(); cmd_bc.delete(); exp_q.delete();
        rx_idx = 0; tx_cnt = 0; vld_cnt = 0; occ = 0; occ_max = 0;
        got_done = 1'b0; got_err = 1'b0; first_dw = '0; last_empty = 2'd3;
        dw        = (len + 3) / 4;
        exp_total = exp_err ? 0 : dw;
        exp_empty = 2'((4 - len % 4) % 4);
        if (!exp_err)
            for (int i = 0; i < dw; i++) exp_q.push_back(bsw(ddr[base + 1 + i / 8][32 * (i % 8) +: 32]));
        @(posedge clk); #1;
        base_addr = ADDR_W'(base);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_on", busy, 1);
    endtask

    task automatic run_pkt(input int base, input int len, input bit exp_err, input string name);
        int t;
        setup_pkt(base, len, exp_err);
        t = 0;
        while (!got_done && !got_err && t < 6000) begin
            @(posedge clk); t++;
        end
        check({name, "_no_timeout"}, t < 6000, 1);
        check({name, "_done"}, got_done, !exp_err);
        check({name, "_error"}, got_err, exp_err);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_busy_off"}, busy, 0);
        check({name, "_dwords"}, tx_cnt, exp_total);
        check({name, "_fifo_peak_ok"}, occ_max <= 128, 1);
    endtask

    localparam logic [31:0] T2_PAY [12] = '{
        32'h4500002E, 32'h00004000, 32'h40110000, 32'hC0A80001,
        32'hC0A80002, 32'h04D2162E, 32'h001A0000, 32'h48656C6C,
        32'h6F2C2077, 32'h6F726C64, 32'h21210A00, 32'h0000DEAD
    };

    initial begin
        int t;
        reset = 1'b1; start = 1'b0; base_addr = '0; cur_base = '1;
        rdy_rand = 1'b0; cmd_rand = 1'b0; rv_en = 1'b1; rv_rand = 1'b0; hold_v = 1'b0;
        n_cmp = 0; n_err = 0; exp_total = 0; rx_idx = 0; tx_cnt = 0; vld_cnt = 0;
        for (int w = 0; w < 512; w++)
            for (int k = 0; k < 8; k++) ddr[w][32 * k +: 32] = {16'(w), 8'(k), 8'h5A};
        ddr[0]   = 256'h40;
        ddr[16]  = 256'h2E;
        for (int i = 0; i < 12; i++) ddr[17 + i / 8][32 * (i % 8) +: 32] = T2_PAY[i];
        ddr[32]  = 256'd4096;
        ddr[200] = 256'd4096;
        ddr[400] = 256'd0;
        ddr[401] = 256'd4097;
        ddr[410] = 256'd320;
        ddr[430] = 256'd46;

        repeat (3) @(posedge clk);
        #1;
        check("rst_amm_read", amm_read, 0);
        check("rst_amm_addr", amm_addr, 0);
        check("rst_amm_bc", amm_bc, 0);
        check("rst_amm_be", amm_be, 32'hFFFF_FFFF);
        check("rst_outputs", {busy, done, err, tx_valid, tx_last, tx_empty}, 0);
        check("rst_tx_data", tx_data, 0);
        reset = 1'b0;

        run_pkt(0, 64, 1'b0, "t1");
        check("t1_ncmd", cmd_a.size(), 2);
        check("t1_cmd0", cmd_word(0), {7'd1, 25'd0});
        check("t1_cmd1", cmd_word(1), {7'd2, 25'd1});
        check("t1_empty", last_empty, 0);

        run_pkt(16, 46, 1'b0, "t2");
        check("t2_first", first_dw, bsw(32'h4500002E));
        check("t2_empty", last_empty, 2);
        check("t2_cmd1", cmd_word(1), {7'd2, 25'd17});

        run_pkt(32, 4096, 1'b0, "t3");
        check("t3_ncmd", cmd_a.size(), 3);
        check("t3_cmd1", cmd_word(1), {7'd64, 25'd33});
        check("t3_cmd2", cmd_word(2), {7'd64, 25'd97});
        check("t3_empty", last_empty, 0);

        rdy_rand = 1'b1; cmd_rand = 1'b1; rv_rand = 1'b1;
        run_pkt(200, 4096, 1'b0, "t4");
        check("t4_cmd1", cmd_word(1), {7'd64, 25'd201});
        check("t4_cmd2", cmd_word(2), {7'd64, 25'd265});
        rdy_rand = 1'b0; cmd_rand = 1'b0; rv_rand = 1'b0;

        run_pkt(400, 0, 1'b1, "t5a");
        check("t5a_ncmd", cmd_a.size(), 1);
        check("t5a_no_valid", vld_cnt, 0);
        run_pkt(401, 4097, 1'b1, "t5b");
        check("t5b_ncmd", cmd_a.size(), 1);
        check("t5b_no_valid", vld_cnt, 0);

        // Hold back payload beats so ten stay outstanding, then reset mid-burst.
        rv_en = 1'b0;
        setup_pkt(410, 320, 1'b0);
        t = 0;
        while (cmd_a.size() < 2 && t < 200) begin
            @(posedge clk); t++;
        end
        check("t6_no_timeout", t < 200, 1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("t6_outstanding", pend.size(), 10);
        check("t6_rst_amm_read", amm_read, 0);
        check("t6_rst_outputs", {busy, done, err, tx_valid, tx_last, tx_empty, amm_bc}, 0);
        check("t6_rst_amm_addr", amm_addr, 0);
        check("t6_rst_amm_be", amm_be, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rv_en = 1'b1;
        vld_cnt = 0;
        t = 0;
        while (pend.size() > 0 && t < 100) begin
            @(posedge clk); t++;
        end
        repeat (2) @(posedge clk);
        check("t6_stray_drained", pend.size(), 0);
        check("t6_stray_no_valid", vld_cnt, 0);
        run_pkt(430, 46, 1'b0, "t6");
        check("t6_empty", last_empty, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/ddr_packet_reader_256.md
Name: ddr_packet_reader_256

Overview:
- Avalon-MM read master that fetches a packet image stored in DDR as 256-bit words and streams it out as 32-bit words to the SFP transmit path.
- DDR layout, per packet:
  - Header word at base_addr; its bits [15:0] hold the packet length in bytes.
  - Payload starts at base_addr+1, eight dwords per 256-bit word, dword 0 in bits [31:0].
- Sits between the DDR controller Avalon-MM port (clk domain) and the tx framer.

Parameters:
- ADDR_W, 25, Avalon word address width.
- MAX_BURST, 64, largest burstcount issued (at most 127).
- FIFO_DEPTH, 128, 256-bit read-data FIFO entries (power of 2, at least MAX_BURST).
- MAX_LEN, 4096, largest legal packet length in bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  header word address, latched on start.
- busy  out  1  high from start acceptance until DONE/ERR exits.
- done  out  1  one-cycle pulse after the last payload dword handshake.
- error  out  1  one-cycle pulse on illegal length.
- amm_addr  out  ADDR_W  burst start address.
- amm_read  out  1  read request.
- amm_burstcount  out  7  beats in the burst.
- amm_byteenable  out  32  constant all ones.
- amm_ready  in  1  slave accepts the command (inverse waitrequest).
- amm_readdata  in  256  read data.
- amm_readdatavalid  in  1  read data beat valid.
- tx_data  out  32  payload dword.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts.
- tx_last  out  1  final dword of the packet.
- tx_empty  out  2  invalid trailing bytes in the last dword; 0 when not last.

Behaviour:
- Reset values: all outputs 0 except amm_byteenable, which is all ones. FSM to IDLE, FIFO emptied, counters cleared.
- FSM states: IDLE, HDR_REQ, HDR_WAIT, CHECK, DATA_REQ, DRAIN, DONE, ERR.
- IDLE:
  - start -> HDR_REQ; latch base_addr.
- HDR_REQ:
  - amm_read=1, amm_addr=base, burstcount=1.
  - Hold all three stable until the cycle amm_read & amm_ready; then -> HDR_WAIT.
- HDR_WAIT:
  - First readdatavalid: len = readdata[15:0] -> CHECK.
  - The header word is never written to the FIFO.
- CHECK (1 cycle):
  - len==0 or len>MAX_LEN -> ERR.
  - Otherwise beats=ceil(len/32), dwords=ceil(len/4), next_addr=base+1, remaining=beats -> DATA_REQ.
- DATA_REQ:
  - burst = min(remaining, MAX_BURST).
  - Assert amm_read only when fifo_count + outstanding + burst <= FIFO_DEPTH; an issued burst can never overflow the FIFO.
  - On acceptance: outstanding += burst, next_addr += burst, remaining -= burst.
  - remaining reaching 0 -> DRAIN.
  - Once asserted, amm_read/addr/burstcount stay stable until accepted.
- Read data:
  - Every readdatavalid beat (outside HDR_WAIT) is pushed into the FIFO and decrements outstanding.
  - Simultaneous accept and beat: outstanding += burst - 1.
- Unpacker:
  - Pops one FIFO word and emits dwords 0..7 in order.
  - Last beat emits only dwords up to the packet's final dword.
  - tx_valid stays high and tx_data stable while tx_ready=0.
  - Zero-bubble: a dword every cycle while the FIFO is non-empty and tx_ready=1, including across 256-bit word boundaries.
- tx_last/tx_empty:
  - tx_last=1 on the dwords-th dword.
  - tx_empty = (4 - len%4)%4 on that dword.
- DRAIN:
  - Wait until outstanding==0 and the last dword handshakes -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- ERR: error=1 for one cycle -> IDLE. No data reads are issued and no tx output is produced.
- busy = (state != IDLE).
- start while busy is ignored.
- Reset mid-operation:
  - Immediate return to IDLE; amm_read deasserts asynchronously.
  - Beats of an abandoned burst that arrive after reset release are discarded; the slave is not reset. Track a discard counter equal to outstanding at reset only if readdatavalid keeps arriving; else ignore.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: DDR_PACKET_READER_BSWAP_EN.
- Defined: each emitted dword is byte-reversed (tx_data[31:24] = dword[7:0], ...), giving network byte order. tx_empty semantics are unchanged.
- Undefined: dwords pass through unmodified.

Test Plan:
- Header len=0x40 at base 0: reads addr 0 (bc 1), then addr 1 (bc 2) -> 16 dwords, tx_last on the 16th, tx_empty=0, done pulse.
- len=0x2E (46 B) with payload 4500002E,00004000,... -> 12 dwords in order, tx_last on the 12th with tx_empty=2.
- len=4096, MAX_BURST=64 -> bursts at base+1 and base+65, bc 64 each; 1024 dwords.
- Random tx_ready (30% low) -> no dword lost or duplicated, amm_read stable while amm_ready=0, FIFO never exceeds 128 entries.
- len=0 and len=4097 -> error pulse, no data bursts, tx_valid stays 0, return to IDLE.
- Reset asserted mid-burst with 10 beats outstanding -> all outputs at reset values; next start on a new packet streams correct data only.
